// File: rtl/slfifo_pkg.sv
// rtl/slfifo_pkg.sv - shared types, defaults and round-robin helper for the slave FIFO write arbiter
//
// Purpose : state encoding, parameter defaults and the two-way round-robin pick
//           function shared by slave_fifo_wr_arbiter and rr_arb2.
// Contents: slfifo_state_t, SLFIFO_DW, SLFIFO_BURST_LEN, rr_pick().
package slfifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGB = 2'd1,
    ST_WRITE      = 2'd2,
    ST_TURNAROUND = 2'd3
  } slfifo_state_t;

  localparam int SLFIFO_DW        = 32;
  localparam int SLFIFO_BURST_LEN = 256;

  // One-hot pick from two requests; on a tie the source not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_src1);
    logic [1:0] pick;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_src1 ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin picker with registered history
//
// Purpose : combinational one-hot pick between two requesters, with the
//           "who was granted last" bit registered and updated on request.
// Ports   : clk_100  - clock (rising edge)
//           reset    - synchronous active-high reset; history becomes "src1 last"
//           req      - request vector, bit N = source N
//           update   - commit the current pick as the new history
//           pick     - one-hot choice, 0 when no request
module rr_arb2
  import slfifo_pkg::*;
(
  input  logic       clk_100,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] pick
);

  logic last_src1;

  assign pick = rr_pick(req, last_src1);

  always_ff @(posedge clk_100) begin
    if (reset) begin
      last_src1 <= 1'b1;
    end else if (update) begin
      last_src1 <= pick[1];
    end
  end

endmodule

// File: rtl/slave_fifo_wr_arbiter.sv
// rtl/slave_fifo_wr_arbiter.sv - two-source burst write arbiter for an FX3 slave FIFO
//
// Purpose : grants one of two word sources per burst (round-robin on ties) and
//           streams its words to the FX3 slave FIFO with registered slwr_n,
//           pktend_n and fifo_data. Bursts end after BURST_LEN words.
// Config  : SLFIFO_PKTEND_EN - when defined, a word with srcN_last=1 also ends
//           the burst and raises pktend_n=0 alongside it for short packets.
// Ports   : clk_100, reset (sync, active-high)
//           enable, flaga_d, flagb_d      - burst start permission and FX3 flags
//           src0_* / src1_*               - valid/data/last in, ready out (combinational)
//           slwr_n, pktend_n, fifo_data   - registered FX3 write interface
//           grant                         - one-hot burst owner, 0 when idle
module slave_fifo_wr_arbiter
  import slfifo_pkg::*;
#(
  parameter int BURST_LEN = SLFIFO_BURST_LEN,
  parameter int DW        = SLFIFO_DW
) (
  input  logic          clk_100,
  input  logic          reset,
  input  logic          enable,
  input  logic          flaga_d,
  input  logic          flagb_d,
  input  logic          src0_valid,
  input  logic [DW-1:0] src0_data,
  input  logic          src0_last,
  output logic          src0_ready,
  input  logic          src1_valid,
  input  logic [DW-1:0] src1_data,
  input  logic          src1_last,
  output logic          src1_ready,
  output logic          slwr_n,
  output logic          pktend_n,
  output logic [DW-1:0] fifo_data,
  output logic [1:0]    grant
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);

  slfifo_state_t state_q;
  logic [CW-1:0] word_cnt;
  logic [1:0]    pick;
  logic          start;
  logic          g_valid;
  logic          g_last;
  logic [DW-1:0] g_data;
  logic          xfer;
  logic [CW-1:0] cnt_next;
  logic          full_end;
  logic          last_end;
  logic          short_pkt;

  assign start = (state_q == ST_IDLE) && enable && flaga_d && (|pick);

  rr_arb2 u_rr_arb2 (
    .clk_100 (clk_100),
    .reset   (reset),
    .req     ({src1_valid, src0_valid}),
    .update  (start),
    .pick    (pick)
  );

  // Grant is one-hot and zero outside a burst, so AND-OR muxing is safe.
  assign g_valid = (grant[0] & src0_valid) | (grant[1] & src1_valid);
  assign g_last  = (grant[0] & src0_last)  | (grant[1] & src1_last);
  assign g_data  = ({DW{grant[0]}} & src0_data) | ({DW{grant[1]}} & src1_data);

  assign xfer       = (state_q == ST_WRITE) && g_valid && flagb_d;
  assign src0_ready = xfer & grant[0];
  assign src1_ready = xfer & grant[1];

  assign cnt_next = word_cnt + 1'b1;
  assign full_end = xfer && (cnt_next == BURST_CNT);

`ifdef SLFIFO_PKTEND_EN
  assign last_end  = xfer && g_last;
  // A last word that also fills the burst is a plain full packet: no pktend.
  assign short_pkt = last_end && !full_end;
`else
  logic unused_last;
  assign unused_last = g_last;
  assign last_end    = 1'b0;
  assign short_pkt   = 1'b0;
`endif

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant     <= 2'b00;
      word_cnt  <= '0;
      slwr_n    <= 1'b1;
      pktend_n  <= 1'b1;
      fifo_data <= '0;
    end else begin
      slwr_n   <= ~xfer;
      pktend_n <= ~short_pkt;
      if (xfer) begin
        fifo_data <= g_data;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            grant    <= pick;
            word_cnt <= '0;
            state_q  <= ST_WAIT_FLAGB;
          end
        end
        ST_WAIT_FLAGB: begin
          if (flagb_d) begin
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (xfer) begin
            word_cnt <= cnt_next;
            if (full_end || last_end) begin
              grant   <= 2'b00;
              state_q <= ST_TURNAROUND;
            end
          end
        end
        ST_TURNAROUND: begin
          state_q <= ST_IDLE;
        end
        default: begin
          grant   <= 2'b00;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_fifo_wr_arbiter.sv
// tb/tb_slave_fifo_wr_arbiter.sv - directed self-checking bench for slave_fifo_wr_arbiter
module tb_slave_fifo_wr_arbiter;
  import slfifo_pkg::*;

  localparam int BL = 4;
  localparam int DW = 32;

  logic          clk_100;
  logic          reset;
  logic          enable;
  logic          flaga_d;
  logic          flagb_d;
  logic          src0_valid;
  logic [DW-1:0] src0_data;
  logic          src0_last;
  logic          src0_ready;
  logic          src1_valid;
  logic [DW-1:0] src1_data;
  logic          src1_last;
  logic          src1_ready;
  logic          slwr_n;
  logic          pktend_n;
  logic [DW-1:0] fifo_data;
  logic [1:0]    grant;

  int n_tests = 0;
  int n_fail  = 0;

  slave_fifo_wr_arbiter #(.BURST_LEN(BL), .DW(DW)) dut (
    .clk_100    (clk_100),
    .reset      (reset),
    .enable     (enable),
    .flaga_d    (flaga_d),
    .flagb_d    (flagb_d),
    .src0_valid (src0_valid),
    .src0_data  (src0_data),
    .src0_last  (src0_last),
    .src0_ready (src0_ready),
    .src1_valid (src1_valid),
    .src1_data  (src1_data),
    .src1_last  (src1_last),
    .src1_ready (src1_ready),
    .slwr_n     (slwr_n),
    .pktend_n   (pktend_n),
    .fifo_data  (fifo_data),
    .grant      (grant)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic set_words(input logic [31:0] v);
    src0_data = 32'hA000_0000 | v;
    src1_data = 32'hB000_0000 | v;
  endtask

  // From IDLE: one edge to WAIT_FLAGB with the expected grant, one more to WRITE.
  task automatic start_burst(input logic [1:0] exp_grant);
    #1;
    check("idle_ready0", 64'(src0_ready), 64'd0);
    check("idle_ready1", 64'(src1_ready), 64'd0);
    step();
    check("grant", 64'(grant), 64'(exp_grant));
    check("state_wait", 64'(dut.state_q), 64'(ST_WAIT_FLAGB));
    step();
    check("state_write", 64'(dut.state_q), 64'(ST_WRITE));
  endtask

  task automatic write_words(input int sel, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      set_words(base + i);
      #1;
      check("ready_granted", 64'(sel ? src1_ready : src0_ready), 64'd1);
      check("ready_other",   64'(sel ? src0_ready : src1_ready), 64'd0);
      step();
      check("slwr_n_xfer", 64'(slwr_n), 64'd0);
      check("fifo_data", 64'(fifo_data),
            64'((sel ? 32'hB000_0000 : 32'hA000_0000) | (base + i)));
    end
  endtask

  task automatic end_burst();
    check("state_turn", 64'(dut.state_q), 64'(ST_TURNAROUND));
    check("grant_turn", 64'(grant), 64'd0);
    step();
    check("state_idle", 64'(dut.state_q), 64'(ST_IDLE));
    check("slwr_n_idle", 64'(slwr_n), 64'd1);
    check("grant_idle", 64'(grant), 64'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; flaga_d = 1'b0; flagb_d = 1'b0;
    src0_valid = 1'b0; src0_last = 1'b0; src1_valid = 1'b0; src1_last = 1'b0;
    set_words(32'h0);
    step();
    step();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_slwr_n", 64'(slwr_n), 64'd1);
    check("rst_pktend_n", 64'(pktend_n), 64'd1);
    check("rst_fifo_data", 64'(fifo_data), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    check("rst_cnt", 64'(dut.word_cnt), 64'd0);
    reset = 1'b0;

    // flaga_d low blocks every burst start
    enable = 1'b1; flagb_d = 1'b1; src0_valid = 1'b1; src1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flaga0_state", 64'(dut.state_q), 64'(ST_IDLE));
      check("flaga0_grant", 64'(grant), 64'd0);
      check("flaga0_slwr_n", 64'(slwr_n), 64'd1);
    end
    src0_valid = 1'b0; src1_valid = 1'b0; flaga_d = 1'b1;
    step();

    // Single full burst from src0
    src0_valid = 1'b1;
    start_burst(2'b01);
    write_words(0, 4, 32'h10);
    check("b1_pktend_n", 64'(pktend_n), 64'd1);
    check("b1_cnt", 64'(dut.word_cnt), 64'd4);
    end_burst();
    check("hold_fifo_data", 64'(fifo_data), 64'h0000_0000_A000_0013);
    src0_valid = 1'b0;

    // Round-robin with both sources always valid, starting from reset history
    reset = 1'b1;
    step();
    reset = 1'b0;
    src0_valid = 1'b1; src1_valid = 1'b1;
    start_burst(2'b01);
    write_words(0, 4, 32'h20);
    end_burst();
    start_burst(2'b10);
    write_words(1, 4, 32'h30);
    end_burst();
    start_burst(2'b01);
    write_words(0, 4, 32'h40);
    end_burst();
    src0_valid = 1'b0; src1_valid = 1'b0;

    // flagb_d stall after word 2
    src0_valid = 1'b1;
    start_burst(2'b01);
    write_words(0, 2, 32'h50);
    flagb_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready0", 64'(src0_ready), 64'd0);
      step();
      check("stall_slwr_n", 64'(slwr_n), 64'd1);
      check("stall_cnt", 64'(dut.word_cnt), 64'd2);
      check("stall_state", 64'(dut.state_q), 64'(ST_WRITE));
    end
    flagb_d = 1'b1;
    write_words(0, 2, 32'h52);
    end_burst();

    // enable dropped mid-burst: burst completes, nothing new starts
    start_burst(2'b01);
    write_words(0, 1, 32'h60);
    enable = 1'b0;
    write_words(0, 3, 32'h61);
    end_burst();
    for (int i = 0; i < 2; i++) begin
      step();
      check("disabled_state", 64'(dut.state_q), 64'(ST_IDLE));
      check("disabled_grant", 64'(grant), 64'd0);
    end
    enable = 1'b1; src0_valid = 1'b0;

    // src1 alone after src0 history; last flag on word 2
    src1_valid = 1'b1;
    start_burst(2'b10);
    write_words(1, 1, 32'h70);
    check("w1_pktend_n", 64'(pktend_n), 64'd1);
    src1_last = 1'b1;
    write_words(1, 1, 32'h71);
`ifdef SLFIFO_PKTEND_EN
    check("short_pktend_n", 64'(pktend_n), 64'd0);
    src1_last = 1'b0;
    end_burst();
    check("short_pktend_rel", 64'(pktend_n), 64'd1);
`else
    check("nolast_pktend_n", 64'(pktend_n), 64'd1);
    src1_last = 1'b0;
    write_words(1, 2, 32'h72);
    check("nolast_pktend_n4", 64'(pktend_n), 64'd1);
    end_burst();
`endif
    src1_valid = 1'b0;

    // Reset mid-burst abandons it and restores "src1 last" history
    src0_valid = 1'b1;
    start_burst(2'b01);
    write_words(0, 1, 32'h80);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_slwr_n", 64'(slwr_n), 64'd1);
    check("mid_rst_grant", 64'(grant), 64'd0);
    check("mid_rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    check("mid_rst_cnt", 64'(dut.word_cnt), 64'd0);
    src1_valid = 1'b1;
    start_burst(2'b01);
    write_words(0, 4, 32'h90);
    end_burst();
    src0_valid = 1'b0; src1_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_fifo_wr_arbiter.md
SLAVE_FIFO_WR_ARBITER -- requirements
Module: slave_fifo_wr_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 256, words per full FIFO packet (power of two, 4..1024).
REQ-002 Parameter DW, default 32, data width.
REQ-003 clk_100  in  1  sole clock, all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  permits new bursts to start.
REQ-006 flaga_d  in  1  registered FX3 full flag; 1 = endpoint buffer available.
REQ-007 flagb_d  in  1  registered FX3 watermark flag; 1 = space for further words.
REQ-008 src0_valid / src1_valid  in  1  requester has a word.
REQ-009 src0_data / src1_data  in  DW  requester word.
REQ-010 src0_last / src1_last  in  1  word ends the requester's packet.
REQ-011 src0_ready / src1_ready  out  1  word accepted this cycle (combinational).
REQ-012 slwr_n  out  1  FX3 write strobe, active low, registered.
REQ-013 pktend_n  out  1  FX3 packet end, active low, registered.
REQ-014 fifo_data  out  DW  FX3 data bus, registered.
REQ-015 grant  out  2  one-hot owner of current burst, 0 when idle.

Function
REQ-016 States: IDLE, WAIT_FLAGB, WRITE, TURNAROUND.
REQ-017 IDLE -> WAIT_FLAGB when enable=1, flaga_d=1, and any srcN_valid=1; grant registered on that transition.
REQ-018 Two valid requesters in IDLE: grant the one not granted last (round-robin); a single valid requester is granted regardless of history.
REQ-019 WAIT_FLAGB -> WRITE when flagb_d=1; otherwise stays.
REQ-020 Transfer occurs in WRITE when granted src valid=1 and flagb_d=1; srcN_ready=1 only then and only for the granted source.
REQ-021 Transfer at cycle t: slwr_n=0 and fifo_data=transferred word at cycle t+1; otherwise slwr_n=1 and fifo_data holds its last value.
REQ-022 Word counter (log2(BURST_LEN)+1 bits) clears on entering WAIT_FLAGB, increments per transfer.
REQ-023 flagb_d=0 or granted valid=0 in WRITE: stall in WRITE, no transfer, counter held.
REQ-024 Burst ends after transfer of word BURST_LEN, or of a word with last=1 (see REQ-030); next state TURNAROUND.
REQ-025 TURNAROUND lasts exactly one cycle, then IDLE; grant=0 there.
REQ-026 Last word and BURST_LEN-th word in same cycle: full-burst end, pktend_n stays 1.
REQ-027 enable deasserted mid-burst: current burst completes normally; no new burst starts.
REQ-028 Non-granted source ready stays 0 for the entire burst.

Reset
REQ-029 reset=1 at an edge: state IDLE, grant=0, counter=0, slwr_n=1, pktend_n=1, fifo_data=0, round-robin history "src1 last" (src0 wins first tie); applies mid-burst, abandoning it.

Configuration
REQ-030 Macro SLFIFO_PKTEND_EN defined: transfer with last=1 ends burst; if counter after transfer < BURST_LEN, pktend_n=0 in the same cycle slwr_n=0 for that word.
REQ-031 SLFIFO_PKTEND_EN undefined: srcN_last ignored, pktend_n constant 1, bursts end only at BURST_LEN.

Structure
REQ-032 Package slfifo_pkg holds the state enum, DW default, and BURST_LEN default.
REQ-033 Sub-module rr_arb2: two-request round-robin picker with registered history, updated on IDLE->WAIT_FLAGB.

Verification
REQ-034 BURST_LEN=4, src0 valid constant, flags 1 -> grant=01, four slwr_n=0 pulses carrying src0 words at 1-cycle latency, one TURNAROUND, pktend_n=1.
REQ-035 Both sources valid continuously, 3 bursts -> grant order 01,10,01; no ready on non-granted source.
REQ-036 flagb_d=0 for 3 cycles after word 2 -> no ready, slwr_n=1 those 3 cycles, counter held, words 3-4 then follow.
REQ-037 SLFIFO_PKTEND_EN, src1 last on word 2 of 4 -> slwr_n=0 and pktend_n=0 together on word 2; without macro -> 4 words, pktend_n=1.
REQ-038 reset pulse after word 1 -> next cycle slwr_n=1, grant=0, state IDLE; subsequent request from src0 and src1 grants src0.
REQ-039 flaga_d=0 with valid requesters -> remains IDLE, grant=0, no slwr_n pulse.
